// File: rtl/wb_ram_arbiter2_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : wb_ram_arbiter2_pkg
// Purpose : Shared definitions for the two-master Wishbone RAM arbiter:
//           grant-state encodings and the watchdog counter width helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package wb_ram_arbiter2_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  // Watchdog counter must hold 0..TIMEOUT. A disabled watchdog (TIMEOUT=0)
  // still gets a 1-bit counter so the vector is never zero-width.
  function automatic int wd_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_ram_arbiter2_arb_rr2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : arb_rr2
// Purpose : Two-way round-robin picker. On a tie the master that did not
//           hold the previous grant wins.
// Ports   : req[1:0]  in   bus requests (bit n = master n)
//           last_gnt  in   index of the master granted last
//           gnt[1:0]  out  one-hot grant, 0 when nobody requests
// Revision: 1.0 - initial release
// ============================================================================
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_ram_arbiter2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : wb_ram_arbiter2
// Purpose : Shares one Wishbone RAM port between two masters. Round-robin
//           grant held for the whole cyc_i assertion, combinational mux of
//           the granted master onto the slave port, and a bus watchdog that
//           answers err_o when the slave never acknowledges.
// Ports   : clk, rst                    clock, async active-high reset
//           m0_* / m1_*                 master ports (adr/dat/we/sel/stb/cyc in,
//                                       dat/ack/err out)
//           s_adr_o..s_cyc_o            request to RAM port
//           s_dat_i, s_ack_i            response from RAM port
// Revision: 1.0 - initial release
// ============================================================================
module wb_ram_arbiter2
  import wb_ram_arbiter2_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i
);

  localparam int                WD_W      = wd_width(TIMEOUT);
  localparam int                WD_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WD_W-1:0]   WD_LAST   = WD_LAST_I[WD_W-1:0];

  logic [1:0]      state, state_next;
  logic            last_gnt, last_gnt_next;
  logic [WD_W-1:0] wd_cnt;
  logic [1:0]      pick;
  logic            rearb;
  logic            granted, sel_m1;
  logic            g_stb, wd_expire, wd_err, bus_ack;

  arb_rr2 u_arb (
    .req      ({m1_cyc_i, m0_cyc_i}),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );

  // A grant is only reconsidered when nobody holds the bus or the holder
  // has dropped cyc_i; this is what keeps bursts locked.
  assign rearb = (state == ST_IDLE) ||
                 ((state == ST_GNT0) && !m0_cyc_i) ||
                 ((state == ST_GNT1) && !m1_cyc_i);

  always_comb begin
    state_next    = state;
    last_gnt_next = last_gnt;
    if (rearb) begin
      case (pick)
        2'b01: begin
          state_next    = ST_GNT0;
          last_gnt_next = 1'b0;
        end
        2'b10: begin
          state_next    = ST_GNT1;
          last_gnt_next = 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_next;
      last_gnt <= last_gnt_next;
    end
  end

  // Slave-side mux; everything is zero while idle.
  assign granted = (state != ST_IDLE);
  assign sel_m1  = (state == ST_GNT1);
  assign g_stb   = granted && (sel_m1 ? m1_stb_i : m0_stb_i);

  // Expiry yields to a same-cycle ack, and the strobe is withdrawn on the
  // error cycle so the slave cannot complete a transfer the master was told
  // had failed.
  assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
  assign wd_err    = g_stb && wd_expire && !s_ack_i;
  assign bus_ack   = granted && s_ack_i;

  assign s_cyc_o = granted;
  assign s_stb_o = g_stb && !wd_err;
  assign s_adr_o = granted ? (sel_m1 ? m1_adr_i : m0_adr_i) : '0;
  assign s_dat_o = granted ? (sel_m1 ? m1_dat_i : m0_dat_i) : '0;
  assign s_sel_o = granted ? (sel_m1 ? m1_sel_i : m0_sel_i) : '0;
  assign s_we_o  = granted && (sel_m1 ? m1_we_i : m0_we_i);

  assign m0_ack_o = (state == ST_GNT0) && s_ack_i;
  assign m1_ack_o = (state == ST_GNT1) && s_ack_i;
  assign m0_err_o = (state == ST_GNT0) && wd_err;
  assign m1_err_o = (state == ST_GNT1) && wd_err;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if ((state_next != state) || bus_ack || wd_err) begin
      wd_cnt <= '0;
    end else if (g_stb) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_arbiter2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_wb_ram_arbiter2
// Purpose : Directed self-checking bench for wb_ram_arbiter2. A main
//           instance (TIMEOUT=16) talks to a small RAM model with registered
//           single-cycle ack; a second instance (TIMEOUT=0) shares the master
//           stimulus against a slave that never acks.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_ram_arbiter2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [31:0] m0_adr = '0, m0_dat = '0, m1_adr = '0, m1_dat = '0;
  logic [3:0]  m0_sel = '0, m1_sel = '0;
  logic        m0_we = 1'b0, m0_stb = 1'b0, m0_cyc = 1'b0;
  logic        m1_we = 1'b0, m1_stb = 1'b0, m1_cyc = 1'b0;

  logic [31:0] m0_rdat, m1_rdat, s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        m0_ack, m0_err, m1_ack, m1_err, s_we, s_stb, s_cyc, s_ack;

  logic [31:0] nt_m0_rdat, nt_m1_rdat, nt_s_adr, nt_s_wdat;
  logic [3:0]  nt_s_sel;
  logic        nt_m0_ack, nt_m0_err, nt_m1_ack, nt_m1_err;
  logic        nt_s_we, nt_s_stb, nt_s_cyc;

  logic        slave_en = 1'b0;
  logic        inj_ack  = 1'b0;
  logic        model_ack;
  logic [31:0] model_dat;
  logic [31:0] mem [0:15];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_ram_arbiter2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we), .s_sel_o(s_sel), .s_stb_o(s_stb),
    .s_cyc_o(s_cyc), .s_dat_i(s_rdat), .s_ack_i(s_ack)
  );

  wb_ram_arbiter2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(nt_m0_rdat), .m0_we_i(m0_we),
    .m0_sel_i(m0_sel), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(nt_m0_ack), .m0_err_o(nt_m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(nt_m1_rdat), .m1_we_i(m1_we),
    .m1_sel_i(m1_sel), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(nt_m1_ack), .m1_err_o(nt_m1_err),
    .s_adr_o(nt_s_adr), .s_dat_o(nt_s_wdat), .s_we_o(nt_s_we), .s_sel_o(nt_s_sel), .s_stb_o(nt_s_stb),
    .s_cyc_o(nt_s_cyc), .s_dat_i(32'h0), .s_ack_i(1'b0)
  );

  // RAM model: registered single-cycle ack, contents restored on reset.
  assign s_ack  = model_ack | inj_ack;
  assign s_rdat = model_dat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_ack <= 1'b0;
      model_dat <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0101_0101 * i;
      mem[0] <= 32'h1122_3344;
      mem[4] <= 32'hDEAD_BEEF;
      mem[8] <= 32'hCAFE_F00D;
    end else begin
      model_ack <= 1'b0;
      if (slave_en && s_cyc && s_stb && !model_ack) begin
        model_ack <= 1'b1;
        if (s_we) begin
          for (int b = 0; b < 4; b++)
            if (s_sel[b]) mem[s_adr[5:2]][8*b +: 8] <= s_wdat[8*b +: 8];
        end else begin
          model_dat <= mem[s_adr[5:2]];
        end
      end
    end
  end

  task automatic idle_masters();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = '0; m0_adr = '0; m0_dat = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = '0; m1_adr = '0; m1_dat = '0;
    inj_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_masters();
    slave_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits up to 10 cycles (sampled on negedges) for the given master's ack.
  task automatic wait_m_ack(input int m, output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    m0_adr = 32'h55; m0_dat = 32'hA5A5_A5A5; m0_sel = 4'hF; m0_we = 1'b1; m0_stb = 1'b1;
    m1_adr = 32'h66; m1_dat = 32'h5A5A_5A5A; m1_sel = 4'hF; m1_we = 1'b1; m1_stb = 1'b1;
    inj_ack = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b expected 0", s_cyc); end
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL reset_s_stb: got %b expected 0", s_stb); end
    checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL reset_s_we: got %b expected 0", s_we); end
    checks++; if ({s_adr, s_wdat, s_sel} !== 68'h0) begin errors++; $display("FAIL reset_s_bus: adr %h dat %h sel %h expected zeros", s_adr, s_wdat, s_sel); end
    checks++; if ({m0_ack, m1_ack, m0_err, m1_err} !== 4'b0000) begin errors++; $display("FAIL reset_ack_err: got %b expected 0000", {m0_ack, m1_ack, m0_err, m1_err}); end
    @(negedge clk);
    checks++; if (s_cyc !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL idle_hold: s_cyc %b m0_ack %b expected 0 0", s_cyc, m0_ack); end
    idle_masters();
  endtask

  task automatic test_single_read();
    do_reset();
    slave_en = 1'b1;
    m0_adr = 32'h10; m0_sel = 4'hF; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL read_latency: s_cyc %b expected 0 before edge", s_cyc); end
    @(negedge clk);
    checks++; if (s_cyc !== 1'b1 || s_stb !== 1'b1 || s_adr !== 32'h10) begin errors++; $display("FAIL read_grant: cyc %b stb %b adr %h expected 1 1 00000010", s_cyc, s_stb, s_adr); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL read_ack_early: got %b expected 0", m0_ack); end
    @(negedge clk);
    checks++; if (m0_ack !== 1'b1 || m0_rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_ack_data: ack %b dat %h expected 1 deadbeef", m0_ack, m0_rdat); end
    checks++; if (m1_ack !== 1'b0 || m1_rdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_other_master: ack %b dat %h expected 0 deadbeef", m1_ack, m1_rdat); end
    idle_masters();
    @(negedge clk);
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL read_release: s_cyc %b expected 0", s_cyc); end
  endtask

  task automatic test_round_robin();
    do_reset();
    m0_adr = 32'h100; m1_adr = 32'h200;
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    @(negedge clk);
    checks++; if (s_adr !== 32'h100) begin errors++; $display("FAIL rr_first_tie: adr %h expected 00000100", s_adr); end
    m0_cyc = 1'b0;
    @(negedge clk);
    checks++; if (s_cyc !== 1'b1 || s_adr !== 32'h200) begin errors++; $display("FAIL rr_handover_m1: cyc %b adr %h expected 1 00000200", s_cyc, s_adr); end
    m0_cyc = 1'b1; m1_cyc = 1'b0;
    @(negedge clk);
    checks++; if (s_cyc !== 1'b1 || s_adr !== 32'h100) begin errors++; $display("FAIL rr_handover_m0: cyc %b adr %h expected 1 00000100", s_cyc, s_adr); end
    m1_cyc = 1'b1; m0_cyc = 1'b0;
    @(negedge clk);
    checks++; if (s_adr !== 32'h200) begin errors++; $display("FAIL rr_handover_m1b: adr %h expected 00000200", s_adr); end
    m1_cyc = 1'b0;
    @(negedge clk);
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rr_idle: cyc %b expected 0", s_cyc); end
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    @(negedge clk);
    checks++; if (s_adr !== 32'h100) begin errors++; $display("FAIL rr_tie_after_m1: adr %h expected 00000100", s_adr); end
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    @(negedge clk);
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    @(negedge clk);
    checks++; if (s_adr !== 32'h200) begin errors++; $display("FAIL rr_tie_after_m0: adr %h expected 00000200", s_adr); end
    idle_masters();
    @(negedge clk);
  endtask

  task automatic test_locked_burst();
    bit got;
    do_reset();
    slave_en = 1'b1;
    m0_adr = 32'h0; m0_we = 1'b1; m0_sel = 4'b0011; m0_dat = 32'hFFFF_1000;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_adr = 32'h20; m1_we = 1'b0; m1_sel = 4'hF; m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_m_ack(0, got);
      checks++;
      if (!got) begin
        errors++; $display("FAIL burst_ack_%0d: no ack within 10 cycles", k);
      end else if (m1_ack !== 1'b0 || s_adr !== 32'h0) begin
        errors++; $display("FAIL burst_locked_%0d: m1_ack %b adr %h expected 0 00000000", k, m1_ack, s_adr);
      end
      if (k < 3) m0_dat = 32'hFFFF_1000 + 32'(k + 1);
      else begin m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; end
    end
    @(negedge clk);
    checks++; if (s_cyc !== 1'b1 || s_adr !== 32'h20) begin errors++; $display("FAIL burst_m1_grant: cyc %b adr %h expected 1 00000020", s_cyc, s_adr); end
    wait_m_ack(1, got);
    checks++; if (!got || m1_rdat !== 32'hCAFE_F00D) begin errors++; $display("FAIL burst_m1_read: ack %b dat %h expected 1 cafef00d", got, m1_rdat); end
    checks++; if (mem[0] !== 32'h1122_1003) begin errors++; $display("FAIL burst_byte_lanes: mem %h expected 11221003", mem[0]); end
    idle_masters();
    @(negedge clk);
  endtask

  task automatic test_watchdog();
    int first_err = 0;
    bit stb_early_low = 1'b0, m1_err_seen = 1'b0, nt_err_seen = 1'b0;
    logic stb_at16 = 1'b1, err_at17 = 1'b1;
    do_reset();
    m0_adr = 32'h40; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (m0_err && first_err == 0) first_err = k;
      if (k < 16 && s_stb !== 1'b1) stb_early_low = 1'b1;
      if (k == 16) stb_at16 = s_stb;
      if (k == 17) err_at17 = m0_err;
      if (m1_err) m1_err_seen = 1'b1;
      if (nt_m0_err) nt_err_seen = 1'b1;
    end
    checks++; if (first_err != 16) begin errors++; $display("FAIL wd_err_cycle: first err at cycle %0d expected 16", first_err); end
    checks++; if (stb_at16 !== 1'b0 || stb_early_low) begin errors++; $display("FAIL wd_stb_mask: stb at 16 %b early low %b expected 0 0", stb_at16, stb_early_low); end
    checks++; if (err_at17 !== 1'b0) begin errors++; $display("FAIL wd_err_pulse: err at 17 %b expected 0", err_at17); end
    checks++; if (m1_err_seen || nt_err_seen) begin errors++; $display("FAIL wd_err_routing: m1 err %b nt err %b expected 0 0", m1_err_seen, nt_err_seen); end
    idle_masters();
    @(negedge clk);
  endtask

  task automatic test_ack_on_expiry();
    bit early_err = 1'b0;
    int nt_errs = 0;
    do_reset();
    m0_adr = 32'h44; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (m0_err) early_err = 1'b1;
    end
    @(negedge clk);
    inj_ack = 1'b1;
    #1;
    checks++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || s_stb !== 1'b1 || early_err) begin errors++; $display("FAIL expiry_ack_wins: ack %b err %b stb %b early %b expected 1 0 1 0", m0_ack, m0_err, s_stb, early_err); end
    @(negedge clk);
    inj_ack = 1'b0;
    #1;
    checks++; if (m0_err !== 1'b0) begin errors++; $display("FAIL expiry_after_ack: err %b expected 0", m0_err); end
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (nt_m0_err) nt_errs++;
    end
    checks++; if (nt_errs != 0 || nt_s_stb !== 1'b1) begin errors++; $display("FAIL wd_disabled: errs %0d stb %b expected 0 1", nt_errs, nt_s_stb); end
    idle_masters();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    bit ack_in_reset = 1'b0;
    do_reset();
    slave_en = 1'b1;
    m1_adr = 32'h30; m1_dat = 32'h1234_5678; m1_sel = 4'hF; m1_we = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    @(negedge clk);
    checks++; if (s_cyc !== 1'b1 || s_adr !== 32'h30) begin errors++; $display("FAIL midrst_grant: cyc %b adr %h expected 1 00000030", s_cyc, s_adr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0 || m1_ack !== 1'b0 || m1_err !== 1'b0) begin errors++; $display("FAIL midrst_abort: cyc %b stb %b ack %b err %b expected 0 0 0 0", s_cyc, s_stb, m1_ack, m1_err); end
    m0_adr = 32'h34; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (m0_ack || m1_ack || m0_err || m1_err) ack_in_reset = 1'b1;
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ack_in_reset) begin errors++; $display("FAIL midrst_quiet: ack/err seen during reset %b expected 0", ack_in_reset); end
    checks++; if (s_cyc !== 1'b1 || s_adr !== 32'h34) begin errors++; $display("FAIL midrst_first_tie: cyc %b adr %h expected 1 00000034", s_cyc, s_adr); end
    idle_masters();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_locked_burst();
    test_watchdog();
    test_ack_on_expiry();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
